// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin arbiter slice.
package arb_pkg;

  localparam int unsigned WIDTH_DEF     = 8;
  localparam int unsigned WIDTH_OUT_DEF = 3;
  localparam int unsigned MAX_HOLD_DEF  = 16;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: round-robin from a start index, or highest-index-wins.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned WIDTH_OUT = WIDTH_OUT_DEF
) (
  input  logic [WIDTH-1:0]     req,
  input  logic [WIDTH_OUT-1:0] start,
  input  logic                 mode,
  output logic [WIDTH_OUT-1:0] idx,
  output logic                 found
);

  logic [WIDTH-1:0] rot;
  int               k;
  int               rr_off;
  int               fx_idx;
  int               sum;

  always_comb begin
    rot    = '0;
    k      = 0;
    rr_off = 0;
    fx_idx = 0;
    sum    = 0;
    found  = |req;
    // Rotate so that bit 0 of rot corresponds to req[start].
    for (int i = 0; i < int'(WIDTH); i++) begin
      k = i + int'(start);
      if (k >= int'(WIDTH)) k = k - int'(WIDTH);
      rot[i] = req[WIDTH_OUT'(k)];
    end
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (rot[i]) rr_off = i;
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (req[i]) fx_idx = i;
    end
    // Rotate the found offset back into absolute index space.
    sum = rr_off + int'(start);
    if (sum >= int'(WIDTH)) sum = sum - int'(WIDTH);
    idx = (mode == MODE_FIXED) ? WIDTH_OUT'(fx_idx) : WIDTH_OUT'(sum);
  end

endmodule

// File: rtl/rr_arbiter8_3.sv
// Eight-way arbiter: registered one-hot grant plus index, held until done,
// request withdrawal, or hold-limit timeout.
module rr_arbiter8_3
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned WIDTH_OUT = WIDTH_OUT_DEF,
  parameter int unsigned MAX_HOLD  = MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req,
  input  logic                 done,
  input  logic                 mode,
  output logic [WIDTH-1:0]     gnt,
  output logic [WIDTH_OUT-1:0] gnt_idx,
  output logic                 gnt_valid,
  output logic                 timeout
);

  localparam int unsigned          CNT_W    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0]     CNT_SAT  = '1;
  localparam logic                 TO_EN    = (MAX_HOLD != 0);
  localparam logic [WIDTH_OUT-1:0] LAST_IDX = WIDTH_OUT'(WIDTH - 1);

  state_e               state, state_nxt;
  logic [CNT_W-1:0]     hold_cnt, hold_nxt;
  logic [WIDTH_OUT-1:0] last_ptr, last_nxt;
  logic [WIDTH-1:0]     gnt_nxt;
  logic [WIDTH_OUT-1:0] idx_nxt;
  logic                 valid_nxt;
  logic                 timeout_nxt;

  logic [WIDTH_OUT-1:0] start_c;
  logic [WIDTH_OUT-1:0] pick_idx;
  logic                 pick_found;
  logic                 owner_req;
  logic                 expired;

  assign start_c   = (last_ptr == LAST_IDX) ? '0 : last_ptr + WIDTH_OUT'(1);
  assign owner_req = req[gnt_idx];
  assign expired   = TO_EN && (hold_cnt == CNT_MAX);

  rr_pick #(
    .WIDTH     (WIDTH),
    .WIDTH_OUT (WIDTH_OUT)
  ) u_pick (
    .req   (req),
    .start (start_c),
    .mode  (mode),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      last_ptr  <= LAST_IDX;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      last_ptr  <= last_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    last_nxt    = last_ptr;
    gnt_nxt     = gnt;
    idx_nxt     = gnt_idx;
    valid_nxt   = gnt_valid;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
        if (pick_found) begin
          gnt_nxt   = WIDTH'(1) << pick_idx;
          idx_nxt   = pick_idx;
          valid_nxt = 1'b1;
          hold_nxt  = CNT_W'(1);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (done || !owner_req || expired) begin
          gnt_nxt     = '0;
          valid_nxt   = 1'b0;
          last_nxt    = gnt_idx;
          hold_nxt    = '0;
          state_nxt   = IDLE;
          // done and withdrawal both outrank the hold limit.
          timeout_nxt = !done && owner_req;
        end else if (hold_cnt != CNT_SAT) begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter8_3.sv
// Directed bench for rr_arbiter8_3: expected grant indices are queued by the
// stimulus and popped by a monitor on every new grant.
module tb_rr_arbiter8_3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  logic [2:0] exp_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic       prev_valid = 1'b0;
  logic       mon_en = 1'b0;

  rr_arbiter8_3 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .mode      (mode),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: every rising gnt_valid must match the next queued index.
  always @(negedge clk) begin
    logic [2:0] e;
    logic [7:0] oh;
    if (rst) begin
      prev_valid = 1'b0;
    end else if (mon_en) begin
      if (gnt_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(gnt_idx), 32'hFFFF_FFFF);
        end else begin
          e  = exp_q.pop_front();
          oh = 8'h01 << e;
          check("grant_idx", 32'(gnt_idx), 32'(e));
          check("grant_onehot", 32'(gnt), 32'(oh));
          check("grant_timeout_low", 32'(timeout), 32'h0);
        end
      end
      prev_valid = gnt_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_idx", 32'(gnt_idx), 32'h0);
    check("rst_valid", 32'(gnt_valid), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    cyc(2);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single requester 0, one-cycle latency
    req = 8'h01; exp_q.push_back(3'd0);
    cyc(1);
    check("t1_valid", 32'(gnt_valid), 32'h1);
    done = 1'b1; cyc(1); done = 1'b0; req = 8'h00;
    cyc(1);

    // Fresh reset, then full round-robin rotation 0..7,0
    rst = 1'b1; cyc(1); rst = 1'b0;
    req = 8'hFF;
    for (int i = 0; i < 9; i++) exp_q.push_back(3'(i % 8));
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      check("rr_busy", 32'(gnt_valid), 32'h1);
      done = 1'b1; cyc(1); done = 1'b0;
      check("rr_idle_gap", 32'(gnt_valid), 32'h0);
      if (i == 8) req = 8'h00;
    end
    cyc(1);

    // Fixed priority: highest index wins, no rotation
    mode = 1'b1; req = 8'h12;
    exp_q.push_back(3'd4); exp_q.push_back(3'd4);
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      done = 1'b1; cyc(1); done = 1'b0;
    end
    req = 8'h00; mode = 1'b0;
    cyc(1);

    // Hold limit: last_ptr=4, req=08 -> idx 3, 16 cycles then timeout
    req = 8'h08; exp_q.push_back(3'd3);
    cyc(1);
    for (int i = 0; i < 16; i++) begin
      check("hold_gnt", 32'(gnt), 32'h08);
      check("hold_no_timeout", 32'(timeout), 32'h0);
      cyc(1);
    end
    check("to_gnt", 32'(gnt), 32'h0);
    check("to_valid", 32'(gnt_valid), 32'h0);
    check("to_pulse", 32'(timeout), 32'h1);
    req = 8'h28; exp_q.push_back(3'd5);
    cyc(1);
    check("to_pulse_once", 32'(timeout), 32'h0);
    done = 1'b1; cyc(1); done = 1'b0; req = 8'h00;
    cyc(1);

    // Owner withdrawal: last_ptr=5, req=04 -> idx 2, then drop
    req = 8'h04; exp_q.push_back(3'd2);
    cyc(1);
    req = 8'h00;
    cyc(1);
    check("wd_gnt", 32'(gnt), 32'h0);
    check("wd_timeout", 32'(timeout), 32'h0);
    check("wd_idx_kept", 32'(gnt_idx), 32'h2);
    // last_ptr=2 makes req=0C pick 3, not 2
    req = 8'h0C; exp_q.push_back(3'd3);
    cyc(1);
    done = 1'b1; cyc(1); done = 1'b0; req = 8'h00;
    cyc(1);

    // done coincident with hold limit: done wins, no timeout
    req = 8'h08; exp_q.push_back(3'd3);
    cyc(1);
    cyc(15);
    check("dto_still_held", 32'(gnt_valid), 32'h1);
    done = 1'b1; cyc(1); done = 1'b0;
    check("dto_released", 32'(gnt_valid), 32'h0);
    check("dto_no_timeout", 32'(timeout), 32'h0);
    req = 8'h00;
    cyc(1);

    // done while idle is ignored
    done = 1'b1; cyc(2); done = 1'b0;
    check("idle_done_valid", 32'(gnt_valid), 32'h0);

    // Async reset mid-grant: last_ptr=3 -> idx 4 first
    req = 8'hFF; exp_q.push_back(3'd4);
    cyc(1);
    @(negedge clk); #1;
    rst = 1'b1; #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_valid", 32'(gnt_valid), 32'h0);
    check("arst_idx", 32'(gnt_idx), 32'h0);
    check("arst_timeout", 32'(timeout), 32'h0);
    cyc(1);
    rst = 1'b0; exp_q.push_back(3'd0);
    cyc(1);
    check("arst_regrant", 32'(gnt), 32'h01);
    done = 1'b1; cyc(1); done = 1'b0; req = 8'h00;
    cyc(3);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
